sensor_input_conditioner: RTL and testbench

SENSOR_INPUT_CONDITIONER -- requirements
Module: sensor_input_conditioner

---
 rtl/sensor_input_conditioner.sv | 103 ++++++++++
 tb/tb_sensor_input_conditioner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_input_conditioner.sv
// Two-flop synchronizers plus tick-qualified debounce filters for six field inputs,
// with a change strobe and a live/sticky water-level consistency monitor.
module sensor_input_conditioner #(
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sample_tick,
    input  logic raw_low_water,
    input  logic raw_mid_water,
    input  logic raw_high_water,
    input  logic raw_earth_humidity,
    input  logic raw_air_humidity,
    input  logic raw_low_temperature,
    input  logic clear_conflict,
    output logic low_water_level,
    output logic mid_water_level,
    output logic high_water_level,
    output logic earth_humidity,
    output logic air_humidity,
    output logic low_temperature,
    output logic sensor_changed,
    output logic conflict_now,
    output logic conflict_latched
);

    localparam int unsigned NumCh = 6;
    localparam logic [4:0] TicksW = 5'(STABLE_TICKS);

    logic [NumCh-1:0]      raw_vec;
    logic [NumCh-1:0]      sync1_q, sync2_q;
    logic [NumCh-1:0]      filt_q, filt_d;
    logic [NumCh-1:0][3:0] cnt_q, cnt_d;
    logic                  changed_q, changed_d;
    logic                  conflict_now_q, conflict_now_d;
    logic                  conflict_latched_q, conflict_latched_d;

    // Bit order: 0 low, 1 mid, 2 high water, 3 earth, 4 air, 5 low temperature.
    assign raw_vec = {raw_low_temperature, raw_air_humidity, raw_earth_humidity,
                      raw_high_water, raw_mid_water, raw_low_water};

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int ch = 0; ch < NumCh; ch++) begin
            if (sync2_q[ch] == filt_q[ch]) begin
                cnt_d[ch] = 4'd0;
            end else if (sample_tick) begin
                // Terminal tick commits the new value and rearms the counter.
                if (({1'b0, cnt_q[ch]} + 5'd1) >= TicksW) begin
                    filt_d[ch] = sync2_q[ch];
                    cnt_d[ch]  = 4'd0;
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        changed_d      = |(filt_d ^ filt_q);
        conflict_now_d = (filt_q[2] & ~filt_q[1]) | (filt_q[1] & ~filt_q[0]) |
                         (filt_q[2] & ~filt_q[0]);
        conflict_latched_d = conflict_latched_q;
        // A live conflict overrides a simultaneous clear request.
        if (conflict_now_q) begin
            conflict_latched_d = 1'b1;
        end else if (clear_conflict) begin
            conflict_latched_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q            <= '0;
            sync2_q            <= '0;
            filt_q             <= '0;
            cnt_q              <= '0;
            changed_q          <= 1'b0;
            conflict_now_q     <= 1'b0;
            conflict_latched_q <= 1'b0;
        end else begin
            sync1_q            <= raw_vec;
            sync2_q            <= sync1_q;
            filt_q             <= filt_d;
            cnt_q              <= cnt_d;
            changed_q          <= changed_d;
            conflict_now_q     <= conflict_now_d;
            conflict_latched_q <= conflict_latched_d;
        end
    end

    assign low_water_level  = filt_q[0];
    assign mid_water_level  = filt_q[1];
    assign high_water_level = filt_q[2];
    assign earth_humidity   = filt_q[3];
    assign air_humidity     = filt_q[4];
    assign low_temperature  = filt_q[5];
    assign sensor_changed   = changed_q;
    assign conflict_now     = conflict_now_q;
    assign conflict_latched = conflict_latched_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed bench: table of tick-period records plus cycle-level sequences for
// strobe width, conflict pipeline, reset mid-debounce and single-tick filtering.
module tb_sensor_input_conditioner;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       sample_tick;
    logic       clear_conflict;
    logic [5:0] raw;
    logic [5:0] dout;
    logic [5:0] dout1;
    logic       chg, cnow, clat;
    logic       chg1, cnow1, clat1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sensor_input_conditioner #(.STABLE_TICKS(4)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .sample_tick        (sample_tick),
        .raw_low_water      (raw[0]),
        .raw_mid_water      (raw[1]),
        .raw_high_water     (raw[2]),
        .raw_earth_humidity (raw[3]),
        .raw_air_humidity   (raw[4]),
        .raw_low_temperature(raw[5]),
        .clear_conflict     (clear_conflict),
        .low_water_level    (dout[0]),
        .mid_water_level    (dout[1]),
        .high_water_level   (dout[2]),
        .earth_humidity     (dout[3]),
        .air_humidity       (dout[4]),
        .low_temperature    (dout[5]),
        .sensor_changed     (chg),
        .conflict_now       (cnow),
        .conflict_latched   (clat)
    );

    sensor_input_conditioner #(.STABLE_TICKS(1)) dut1 (
        .clock              (clock),
        .reset_n            (reset_n),
        .sample_tick        (sample_tick),
        .raw_low_water      (raw[0]),
        .raw_mid_water      (raw[1]),
        .raw_high_water     (raw[2]),
        .raw_earth_humidity (raw[3]),
        .raw_air_humidity   (raw[4]),
        .raw_low_temperature(raw[5]),
        .clear_conflict     (clear_conflict),
        .low_water_level    (dout1[0]),
        .mid_water_level    (dout1[1]),
        .high_water_level   (dout1[2]),
        .earth_humidity     (dout1[3]),
        .air_humidity       (dout1[4]),
        .low_temperature    (dout1[5]),
        .sensor_changed     (chg1),
        .conflict_now       (cnow1),
        .conflict_latched   (clat1)
    );

    typedef struct {
        logic [5:0] raw;
        logic       clr;
        logic [5:0] eout;
        logic       echg;
        logic       ecn;
        logic       ecl;
    } row_t;

    row_t tbl[64];
    int   n_rows = 0;

    task automatic add(input logic [5:0] r, input logic c, input logic [5:0] eo,
                       input logic eg, input logic en, input logic el);
        tbl[n_rows] = '{raw: r, clr: c, eout: eo, echg: eg, ecn: en, ecl: el};
        n_rows++;
    endtask

    // One clock: drive inputs, take the edge, settle past it.
    task automatic cyc(input logic [5:0] r, input logic t, input logic c, input logic rn);
        raw            = r;
        sample_tick    = t;
        clear_conflict = c;
        reset_n        = rn;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] eo, input logic eg,
                         input logic en, input logic el);
        logic [8:0] act, exp;
        act = {dout, chg, cnow, clat};
        exp = {eo, eg, en, el};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got out=%b chg=%b cnow=%b clat=%b, want out=%b chg=%b cnow=%b clat=%b",
                     name, dout, chg, cnow, clat, eo, eg, en, el);
        end
    endtask

    task automatic check1(input string name, input logic [5:0] eo);
        checks++;
        if (dout1 !== eo) begin
            errors++;
            $display("FAIL %s: got out1=%b, want out1=%b", name, dout1, eo);
        end
    endtask

    initial begin
        raw = '0; sample_tick = 1'b0; clear_conflict = 1'b0; reset_n = 1'b0;

        // Each row: four clocks at the row's raw value, tick (and clear) on the fourth.
        add(6'b000000, 0, 6'b000000, 0, 0, 0);
        add(6'b000001, 0, 6'b000000, 0, 0, 0);
        add(6'b000001, 0, 6'b000000, 0, 0, 0);
        add(6'b000001, 0, 6'b000000, 0, 0, 0);
        add(6'b000001, 0, 6'b000001, 1, 0, 0);   // low water qualifies on 4th tick
        add(6'b000001, 0, 6'b000001, 0, 0, 0);
        add(6'b001001, 0, 6'b000001, 0, 0, 0);   // earth glitch, three ticks only
        add(6'b001001, 0, 6'b000001, 0, 0, 0);
        add(6'b001001, 0, 6'b000001, 0, 0, 0);
        add(6'b000001, 0, 6'b000001, 0, 0, 0);
        add(6'b001001, 0, 6'b000001, 0, 0, 0);   // counter must restart from zero
        add(6'b001001, 0, 6'b000001, 0, 0, 0);
        add(6'b001001, 0, 6'b000001, 0, 0, 0);
        add(6'b001001, 0, 6'b001001, 1, 0, 0);
        add(6'b000001, 0, 6'b001001, 0, 0, 0);
        add(6'b000001, 0, 6'b001001, 0, 0, 0);
        add(6'b000001, 0, 6'b001001, 0, 0, 0);
        add(6'b000001, 0, 6'b000001, 1, 0, 0);
        add(6'b000010, 0, 6'b000001, 0, 0, 0);   // mid without low: conflict
        add(6'b000010, 0, 6'b000001, 0, 0, 0);
        add(6'b000010, 0, 6'b000001, 0, 0, 0);
        add(6'b000010, 0, 6'b000010, 1, 0, 0);
        add(6'b000010, 0, 6'b000010, 0, 1, 1);
        add(6'b000010, 1, 6'b000010, 0, 1, 1);   // clear loses to live conflict
        add(6'b000011, 0, 6'b000010, 0, 1, 1);
        add(6'b000011, 0, 6'b000010, 0, 1, 1);
        add(6'b000011, 0, 6'b000010, 0, 1, 1);
        add(6'b000011, 0, 6'b000011, 1, 1, 1);
        add(6'b000011, 1, 6'b000011, 0, 0, 0);   // clear honoured once conflict gone
        add(6'b000011, 0, 6'b000011, 0, 0, 0);
        add(6'b000000, 0, 6'b000011, 0, 0, 0);
        add(6'b000000, 0, 6'b000011, 0, 0, 0);
        add(6'b000000, 0, 6'b000011, 0, 0, 0);
        add(6'b000000, 0, 6'b000000, 1, 0, 0);
        add(6'b000111, 0, 6'b000000, 0, 0, 0);   // all water levels together
        add(6'b000111, 0, 6'b000000, 0, 0, 0);
        add(6'b000111, 0, 6'b000000, 0, 0, 0);
        add(6'b000111, 0, 6'b000111, 1, 0, 0);
        add(6'b000111, 0, 6'b000111, 0, 0, 0);
        add(6'b110111, 0, 6'b000111, 0, 0, 0);
        add(6'b110111, 0, 6'b000111, 0, 0, 0);
        add(6'b110111, 0, 6'b000111, 0, 0, 0);
        add(6'b110111, 0, 6'b110111, 1, 0, 0);

        cyc(6'b000000, 1, 1, 0);
        cyc(6'b000000, 0, 0, 0);
        check("reset", 6'b000000, 0, 0, 0);

        for (int i = 0; i < n_rows; i++) begin
            cyc(tbl[i].raw, 0, 0, 1);
            cyc(tbl[i].raw, 0, 0, 1);
            cyc(tbl[i].raw, 0, 0, 1);
            cyc(tbl[i].raw, 1, tbl[i].clr, 1);
            check($sformatf("row%0d", i), tbl[i].eout, tbl[i].echg, tbl[i].ecn, tbl[i].ecl);
        end

        // Low water drops under high water: cycle-accurate strobe and conflict pipeline.
        cyc(6'b110110, 0, 0, 1);
        cyc(6'b110110, 0, 0, 1);
        cyc(6'b110110, 1, 0, 1);
        cyc(6'b110110, 1, 0, 1);
        cyc(6'b110110, 1, 0, 1);
        check("drop_tick3", 6'b110111, 0, 0, 0);
        cyc(6'b110110, 1, 0, 1);
        check("drop_tick4", 6'b110110, 1, 0, 0);
        cyc(6'b110110, 0, 0, 1);
        check("drop_cnow", 6'b110110, 0, 1, 0);
        cyc(6'b110110, 0, 0, 1);
        check("drop_clat", 6'b110110, 0, 1, 1);
        cyc(6'b110110, 0, 1, 1);
        check("drop_clr_blocked", 6'b110110, 0, 1, 1);

        // Reset with the low-water counter at 2 and a conflict latched.
        cyc(6'b110111, 0, 0, 1);
        cyc(6'b110111, 0, 0, 1);
        cyc(6'b110111, 1, 0, 1);
        cyc(6'b110111, 1, 0, 1);
        check("mid_debounce", 6'b110110, 0, 1, 1);
        cyc(6'b110111, 1, 1, 0);
        check("reset_mid", 6'b000000, 0, 0, 0);
        check1("reset_mid_st1", 6'b000000);
        cyc(6'b110111, 0, 0, 1);
        cyc(6'b110111, 0, 0, 1);
        cyc(6'b110111, 1, 0, 1);
        check("requal_tick1", 6'b000000, 0, 0, 0);
        check1("st1_first_tick", 6'b110111);
        cyc(6'b110111, 1, 0, 1);
        cyc(6'b110111, 1, 0, 1);
        check("requal_tick3", 6'b000000, 0, 0, 0);
        cyc(6'b110111, 1, 0, 1);
        check("requal_tick4", 6'b110111, 1, 0, 0);
        cyc(6'b110111, 0, 0, 1);
        check("requal_after", 6'b110111, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
